// File: rtl/bus_grant_encoder.sv
// Registered N-way bus grant encoder: fixed-priority or round-robin winner,
// held as a locked grant until release or MAX_HOLD timeout.
module bus_grant_encoder #(
  parameter int N        = 32,
  parameter int W        = $clog2(N),
  parameter int MODE     = 0,
  parameter int MAX_HOLD = 0
) (
  input  logic         i_clk,
  input  logic         i_clr,
  input  logic [N-1:0] i_req,
  input  logic         i_release,
  output logic         o_grant_valid,
  output logic [W-1:0] o_grant_idx,
  output logic [N-1:0] o_grant_onehot,
  output logic         o_timeout
);

  typedef enum logic [0:0] {IDLE, GRANTED} state_t;

  localparam bit         HOLD_EN   = (MAX_HOLD != 0);
  localparam logic [7:0] HOLD_LAST = (MAX_HOLD == 0) ? 8'd0 : 8'(MAX_HOLD - 1);
  localparam logic [N-1:0] ONE     = {{(N-1){1'b0}}, 1'b1};

  state_t       r_state;
  logic         r_valid;
  logic [W-1:0] r_idx;
  logic [N-1:0] r_onehot;
  logic         r_timeout;
  logic [7:0]   r_hold;
  logic [W-1:0] r_last;

  state_t       w_state_nxt;
  logic         w_valid_nxt;
  logic [W-1:0] w_idx_nxt;
  logic [N-1:0] w_onehot_nxt;
  logic         w_timeout_nxt;
  logic [7:0]   w_hold_nxt;
  logic [W-1:0] w_last_nxt;
  logic [W-1:0] w_winner;
  logic         w_any;
  logic         w_hold_hit;
  int           w_pos;

  // Winner select. Loops run from lowest to highest priority so the final
  // assignment is the winner; round-robin walks last-N .. last-1 (mod N).
  always_comb begin
    w_winner = '0;
    w_pos    = 0;
    if (MODE == 0) begin
      for (int i = 0; i < N; i++) begin
        if (i_req[i]) w_winner = W'(i);
      end
    end else begin
      for (int k = N; k >= 1; k--) begin
        w_pos = int'(r_last) + N - k;
        if (w_pos >= N) w_pos = w_pos - N;
        if (i_req[w_pos]) w_winner = W'(w_pos);
      end
    end
  end

  assign w_any      = |i_req;
  assign w_hold_hit = HOLD_EN && (r_hold == HOLD_LAST);

  always_comb begin
    w_state_nxt   = r_state;
    w_valid_nxt   = r_valid;
    w_idx_nxt     = r_idx;
    w_onehot_nxt  = r_onehot;
    w_timeout_nxt = 1'b0;
    w_hold_nxt    = r_hold;
    w_last_nxt    = r_last;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state_nxt  = GRANTED;
          w_valid_nxt  = 1'b1;
          w_idx_nxt    = w_winner;
          w_onehot_nxt = ONE << w_winner;
          w_hold_nxt   = '0;
          w_last_nxt   = w_winner;
        end
      end
      GRANTED: begin
        if (i_release || w_hold_hit) begin
          // release wins over a coincident timeout, so no pulse then
          w_timeout_nxt = ~i_release;
          if (w_any) begin
            w_valid_nxt  = 1'b1;
            w_idx_nxt    = w_winner;
            w_onehot_nxt = ONE << w_winner;
            w_hold_nxt   = '0;
            w_last_nxt   = w_winner;
          end else begin
            w_state_nxt  = IDLE;
            w_valid_nxt  = 1'b0;
            w_idx_nxt    = '0;
            w_onehot_nxt = '0;
          end
        end else if (r_hold != 8'hFF) begin
          w_hold_nxt = r_hold + 8'd1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_state   <= IDLE;
      r_valid   <= 1'b0;
      r_idx     <= '0;
      r_onehot  <= '0;
      r_timeout <= 1'b0;
      r_hold    <= '0;
      r_last    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_valid   <= w_valid_nxt;
      r_idx     <= w_idx_nxt;
      r_onehot  <= w_onehot_nxt;
      r_timeout <= w_timeout_nxt;
      r_hold    <= w_hold_nxt;
      r_last    <= w_last_nxt;
    end
  end

  assign o_grant_valid  = r_valid;
  assign o_grant_idx    = r_idx;
  assign o_grant_onehot = r_onehot;
  assign o_timeout      = r_timeout;

endmodule

// File: tb/tb_bus_grant_encoder.sv
// Bench for bus_grant_encoder: four configurations driven in lockstep and
// compared every cycle against a grant-age reference model.
module tb_bus_grant_encoder;

  logic        clk = 1'b0;
  logic        clr;
  logic        rel;
  logic [31:0] req;

  always #5 clk = ~clk;

  logic        gv0, gv1, gv2, gv3;
  logic [4:0]  gi0, gi1, gi2;
  logic [2:0]  gi3;
  logic [31:0] oh0, oh1, oh2;
  logic [4:0]  oh3;
  logic        to0, to1, to2, to3;

  bus_grant_encoder #(.N(32), .MODE(0), .MAX_HOLD(0)) u_fp (
    .i_clk(clk), .i_clr(clr), .i_req(req), .i_release(rel),
    .o_grant_valid(gv0), .o_grant_idx(gi0), .o_grant_onehot(oh0), .o_timeout(to0));
  bus_grant_encoder #(.N(32), .MODE(1), .MAX_HOLD(3)) u_rr (
    .i_clk(clk), .i_clr(clr), .i_req(req), .i_release(rel),
    .o_grant_valid(gv1), .o_grant_idx(gi1), .o_grant_onehot(oh1), .o_timeout(to1));
  bus_grant_encoder #(.N(32), .MODE(0), .MAX_HOLD(3)) u_fpt (
    .i_clk(clk), .i_clr(clr), .i_req(req), .i_release(rel),
    .o_grant_valid(gv2), .o_grant_idx(gi2), .o_grant_onehot(oh2), .o_timeout(to2));
  bus_grant_encoder #(.N(5), .MODE(1), .MAX_HOLD(0)) u_n5 (
    .i_clk(clk), .i_clr(clr), .i_req(req[4:0]), .i_release(rel),
    .o_grant_valid(gv3), .o_grant_idx(gi3), .o_grant_onehot(oh3), .o_timeout(to3));

  int n_of  [4] = '{32, 32, 32, 5};
  int mode_of[4] = '{0, 1, 0, 1};
  int mh_of [4] = '{0, 3, 3, 0};

  int checks = 0;
  int errors = 0;

  // Model state: whether a grant is held, owner, cycles it has been visible,
  // most recent winner, and expected timeout pulse.
  bit m_valid[4];
  int m_idx  [4];
  int m_age  [4];
  int m_last [4];
  bit m_to   [4];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input int d, input logic [63:0] r);
    int n = n_of[d];
    if (mode_of[d] == 0) begin
      for (int i = n - 1; i >= 0; i--) if (r[i]) return i;
    end else begin
      for (int k = 1; k <= n; k++) begin
        int j = (m_last[d] - k + n) % n;
        if (r[j]) return j;
      end
    end
    return -1;
  endfunction

  task automatic model_edge(input int d);
    logic [63:0] r;
    int w;
    r = {32'd0, req} & ((64'd1 << n_of[d]) - 64'd1);
    m_to[d] = 1'b0;
    if (clr) begin
      m_valid[d] = 1'b0; m_idx[d] = 0; m_age[d] = 0; m_last[d] = 0;
    end else begin
      bit ends = 1'b0;
      if (!m_valid[d]) ends = (r != 0);
      else begin
        bit tmo = (mh_of[d] != 0) && (m_age[d] == mh_of[d]);
        ends = rel || tmo;
        m_to[d] = tmo && !rel;
      end
      if (m_valid[d] && !ends) m_age[d]++;
      else if (ends) begin
        if (r != 0) begin
          w = pick(d, r);
          m_valid[d] = 1'b1; m_idx[d] = w; m_last[d] = w; m_age[d] = 1;
        end else begin
          m_valid[d] = 1'b0; m_idx[d] = 0;
        end
      end
    end
  endtask

  task automatic compare(input int d);
    logic        v, t;
    logic [63:0] ix, oh, exp_oh;
    case (d)
      0: begin v = gv0; ix = 64'(gi0); oh = 64'(oh0); t = to0; end
      1: begin v = gv1; ix = 64'(gi1); oh = 64'(oh1); t = to1; end
      2: begin v = gv2; ix = 64'(gi2); oh = 64'(oh2); t = to2; end
      default: begin v = gv3; ix = 64'(gi3); oh = 64'(oh3); t = to3; end
    endcase
    exp_oh = m_valid[d] ? (64'd1 << m_idx[d]) : 64'd0;
    check($sformatf("valid[%0d]", d), 64'(v), 64'(m_valid[d]));
    check($sformatf("idx[%0d]", d), ix, 64'(m_idx[d]));
    check($sformatf("onehot[%0d]", d), oh, exp_oh);
    check($sformatf("timeout[%0d]", d), 64'(t), 64'(m_to[d]));
  endtask

  task automatic step();
    @(posedge clk);
    for (int d = 0; d < 4; d++) model_edge(d);
    #1;
    for (int d = 0; d < 4; d++) compare(d);
  endtask

  int rr_exp[5] = '{8, 4, 0, 8, 4};

  initial begin
    clr = 1'b1; rel = 1'b0; req = '0;
    for (int d = 0; d < 4; d++) begin
      m_valid[d] = 0; m_idx[d] = 0; m_age[d] = 0; m_last[d] = 0; m_to[d] = 0;
    end
    repeat (3) step();
    clr = 1'b0;
    step();
    check("reset_valid", 64'(gv0), 64'd0);
    check("reset_idx", 64'(gi0), 64'd0);

    // first grant and lock
    req = 32'h0000_0012; step();
    check("first_idx", 64'(gi0), 64'd4);
    check("first_onehot", 64'(oh0), 64'h10);
    req = 32'h8000_0010; step(); step();
    check("locked_idx", 64'(gi0), 64'd4);
    rel = 1'b1; step();
    check("handover_idx", 64'(gi0), 64'd31);
    check("handover_valid", 64'(gv0), 64'd1);
    req = '0; step();
    check("idle_valid", 64'(gv0), 64'd0);
    check("idle_idx", 64'(gi0), 64'd0);

    // round-robin rotation with release every cycle
    rel = 1'b0; clr = 1'b1; step(); clr = 1'b0;
    req = 32'h0000_0111; rel = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("rr_seq%0d", i), 64'(gi1), 64'(rr_exp[i]));
    end
    req = 32'h0000_0101; step();
    check("rr_skip", 64'(gi1), 64'd0);
    step();
    check("rr_wrap", 64'(gi1), 64'd8);

    // timeout
    rel = 1'b0; req = '0; clr = 1'b1; step(); clr = 1'b0;
    req = 32'h0000_0003;
    step();
    check("to_first_rr", 64'(gi1), 64'd1);
    step(); step();
    check("to_held_rr", 64'(gi1), 64'd1);
    check("to_nopulse", 64'(to1), 64'd0);
    step();
    check("to_pulse_rr", 64'(to1), 64'd1);
    check("to_next_rr", 64'(gi1), 64'd0);
    check("to_pulse_fp", 64'(to2), 64'd1);
    check("to_regrant_fp", 64'(gi2), 64'd1);
    step(); step();
    check("to_pulse_once", 64'(to1), 64'd0);
    step();
    check("to_second_rr", 64'(gi1), 64'd1);
    // release coinciding with the third held cycle suppresses the pulse
    step(); step(); rel = 1'b1; step(); rel = 1'b0;
    check("coinc_no_to", 64'(to1), 64'd0);
    check("coinc_rr_idx", 64'(gi1), 64'd0);

    // clr beats release and requests
    req = 32'h0000_0111; rel = 1'b1; clr = 1'b1; step();
    check("clr_valid", 64'(gv1), 64'd0);
    check("clr_timeout", 64'(to1), 64'd0);
    clr = 1'b0; rel = 1'b0; step();
    check("clr_rr_highest", 64'(gi1), 64'd8);

    // non-power-of-two instance
    clr = 1'b1; step(); clr = 1'b0;
    req = 32'h0000_0011; step();
    check("n5_start", 64'(gi3), 64'd4);
    check("n5_onehot", 64'(oh3), 64'h10);

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      req = $urandom() & $urandom() & $urandom();
      if ($urandom_range(0, 7) == 0) req = '0;
      rel = ($urandom_range(0, 3) == 0);
      clr = ($urandom_range(0, 49) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_grant_encoder.md
# bus_grant_encoder

Registered, parametrised successor to the team's 32-to-5 bus-select priority encoder. It samples N request lines and selects one winner using either fixed priority (highest index wins) or round-robin. The winner is held as a locked grant until the owner releases it or a hold timeout expires. It sits between the control unit's register-out strobes and the bus multiplexer, and drives both the encoded select and a one-hot grant.

## Interface
- `N`, 32: number of request lines; legal range 2..64.
- `W`, `$clog2(N)`: width of the encoded grant index.
- `MODE`, 0: arbitration policy; 0 = fixed priority (highest index wins), 1 = round-robin.
- `MAX_HOLD`, 0: maximum grant length in cycles before forced release; 0 = no limit. Legal range 0..255.

- `clk`, input, 1: single clock; all state changes on the rising edge.
- `clr`, input, 1: synchronous, active-high reset.
- `req`, input, N: request lines; bit i = source i wants the bus.
- `release`, input, 1: the current owner gives up the grant; ignored while `grant_valid`=0.
- `grant_valid`, output, 1: a grant is held.
- `grant_idx`, output, W: index of the owner; 0 when `grant_valid`=0.
- `grant_onehot`, output, N: one-hot owner; all zeros when `grant_valid`=0.
- `timeout`, output, 1: one-cycle pulse when a grant is forcibly ended by `MAX_HOLD`.

## Operation
- The state machine has two states, IDLE and GRANTED. All outputs are registered.
- **IDLE:**
  - If `|req`=1, compute the winner, load `grant_idx`/`grant_onehot`, set `grant_valid`, clear the hold counter, and go to GRANTED.
  - Otherwise stay in IDLE.
- **GRANTED:**
  - The grant is locked. Changes on `req`, including the owner dropping its request, do not alter the grant.
  - The hold counter increments each cycle, saturating at 255.
- **End of grant.** A grant ends on `release`=1, or when `MAX_HOLD`≠0 and the counter reaches `MAX_HOLD`-1 (the grant lasts exactly `MAX_HOLD` cycles). On that edge:
  - If `|req`=1, re-arbitrate immediately. The new winner is registered on the same edge, so there is no idle bubble, and the previous owner is eligible under the policy.
  - If `|req`=0, clear `grant_valid`, `grant_idx` and `grant_onehot`, and go to IDLE.
  - A timeout-caused end also pulses `timeout`=1 for that one cycle. If `release` and the timeout coincide, `release` takes precedence and there is no `timeout` pulse.
- **Fixed priority (MODE=0):** the winner is the highest set bit of `req`, identical to the legacy encoder's ordering.
- **Round-robin (MODE=1):**
  - Pointer `last` (W bits) holds the most recent winner.
  - Search order is `last`-1, `last`-2, …, 0, N-1, …, `last`, with indices taken modulo N. The first set bit wins.
  - `last` updates only when a new grant is issued.
  - Reset value of `last` is 0. The first search after reset therefore starts at N-1 and matches fixed priority.
- **Width rules:** `grant_idx` is zero-extended when N is not a power of two. Indices ≥ N are never produced.
- **Reset (`clr`=1 at an edge):** takes priority over everything, including mid-grant and same-cycle `release`. Results:
  - State = IDLE; `grant_valid`=0, `grant_idx`=0, `grant_onehot`=0, `timeout`=0.
  - Hold counter = 0, `last` = 0.
  - Arbitration resumes on the first edge with `clr`=0.

## Timing
- Request-to-grant latency is 1 cycle. `req` sampled at edge t gives the grant visible after edge t.
- Release-to-next-grant latency is 1 cycle: `release` sampled at edge t gives the new owner (or idle) after edge t.
- A grant lasts at least 1 cycle. A `release` held high on consecutive cycles ends consecutive grants, one per edge.
- `timeout` is high for exactly one cycle, aligned with the edge that issues the replacement grant or goes idle.
- There is no combinational path from any input to any output.

## Test plan
- **Reset and first grant:** reset for 3 cycles, then `req`=0x0000_0000 → all outputs 0. Then `req`=0x0000_0012 (N=32, MODE=0) → after 1 edge, `grant_valid`=1, `grant_idx`=4, `grant_onehot`=0x10.
- **Locked grant:** while idx 4 is held, raise `req`=0x8000_0010 → grant stays at 4 until `release`. With `release`=1, the next edge gives `grant_idx`=31 with no idle cycle. A further `release` with `req`=0 → `grant_valid`=0, `grant_idx`=0.
- **Round-robin rotation:** MODE=1, `req`=0x0000_0111 held, `release` pulsed every cycle → grant sequence 8, 4, 0, 8, 4. Clearing bit 4 mid-sequence skips it.
- **Timeout:** MAX_HOLD=3, `req`=0x0000_0003, `release` never asserted → idx 1 held 3 cycles, then `timeout` pulses and idx 0 is granted for 3 cycles (MODE=1). In MODE=0, idx 1 is re-granted instead.
- **Coincident events:** `release` and the timeout on the same edge → no `timeout` pulse. `clr` together with `release` and `req`≠0 → outputs 0 and round-robin pointer reset, so the next winner is the highest index.
- **Non-power-of-two width:** N=5, `req`=0b10000 → `grant_idx`=4, W=3. With MODE=1 and `last`=0, the search begins at 4, never at 7.
